// File: rtl/memory_access_unit.sv
// Memory stage of the pipelined ARM core: issues loads/stores over a
// request/grant/response handshake and registers the result for MEM/WB.
package memory_access_unit_pkg;
    parameter int WORD       = 32;
    parameter int ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        ALU_RESULT = 2'd0,
        MEM_DATA   = 2'd1,
        PC_NEXT    = 2'd2
    } reg_file_data_source;
endpackage

module memory_access_unit
    import memory_access_unit_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  is_valid_i,
    input  logic                  mem_write_en_i,
    input  logic                  reg_file_write_en_i,
    input  reg_file_data_source   reg_file_data_source_i,
    input  logic [ADDR_WIDTH-1:0] reg_dest_addr_i,
    input  logic [WORD-1:0]       alu_result_i,
    input  logic [WORD-1:0]       reg_2_data_i,
    output logic                  stall_o,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [WORD-1:0]       dmem_addr_o,
    output logic [WORD-1:0]       dmem_wdata_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [WORD-1:0]       dmem_rdata_i,
    output logic                  is_valid_o,
    output logic                  reg_file_write_en_o,
    output logic [ADDR_WIDTH-1:0] reg_dest_addr_o,
    output logic [WORD-1:0]       result_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t                state;
    logic                  cap_is_store;
    logic                  cap_write_en;
    logic [ADDR_WIDTH-1:0] cap_dest;

    logic is_store;
    logic is_mem_op;
    logic is_misaligned;

    // A store takes priority when an instruction is flagged as both store and load.
    assign is_store      = mem_write_en_i;
    assign is_mem_op     = is_valid_i && (mem_write_en_i || (reg_file_data_source_i == MEM_DATA));
    assign is_misaligned = (alu_result_i[1:0] != 2'b00);
    assign stall_o       = (state != IDLE);

    // NOTE: every register here uses non-blocking assignment so all state
    // updates see the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state               <= IDLE;
            cap_is_store        <= 1'b0;
            cap_write_en        <= 1'b0;
            cap_dest            <= '0;
            dmem_req_o          <= 1'b0;
            dmem_we_o           <= 1'b0;
            dmem_addr_o         <= '0;
            dmem_wdata_o        <= '0;
            is_valid_o          <= 1'b0;
            reg_file_write_en_o <= 1'b0;
            reg_dest_addr_o     <= '0;
            result_o            <= '0;
            err_o               <= 1'b0;
        end else begin
            // Pulse outputs default low; only a completing instruction raises them.
            is_valid_o          <= 1'b0;
            reg_file_write_en_o <= 1'b0;
            err_o               <= 1'b0;

            case (state)
                IDLE: begin
                    if (is_valid_i && !is_mem_op) begin
                        is_valid_o          <= 1'b1;
                        reg_file_write_en_o <= reg_file_write_en_i;
                        reg_dest_addr_o     <= reg_dest_addr_i;
                        result_o            <= alu_result_i;
                    end else if (is_mem_op && is_misaligned) begin
                        err_o <= 1'b1;
                    end else if (is_mem_op) begin
                        state        <= REQ;
                        dmem_req_o   <= 1'b1;
                        dmem_we_o    <= is_store;
                        dmem_addr_o  <= alu_result_i;
                        dmem_wdata_o <= reg_2_data_i;
                        cap_is_store <= is_store;
                        cap_write_en <= reg_file_write_en_i;
                        cap_dest     <= reg_dest_addr_i;
                    end
                end

                REQ: begin
                    if (dmem_gnt_i) begin
                        dmem_req_o <= 1'b0;
                        dmem_we_o  <= 1'b0;
                        if (cap_is_store) begin
                            state               <= IDLE;
                            is_valid_o          <= 1'b1;
                            reg_file_write_en_o <= cap_write_en;
                            reg_dest_addr_o     <= cap_dest;
                            result_o            <= dmem_addr_o;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    if (dmem_rvalid_i) begin
                        state               <= IDLE;
                        is_valid_o          <= 1'b1;
                        reg_file_write_en_o <= cap_write_en;
                        reg_dest_addr_o     <= cap_dest;
                        result_o            <= dmem_rdata_i;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: ALU pass-through, store, delayed
// load, misalignment, back-to-back hazard and mid-transaction reset.
module tb_memory_access_unit;
    import memory_access_unit_pkg::*;

    logic                  clk_i = 1'b0;
    logic                  reset_i;
    logic                  is_valid_i;
    logic                  mem_write_en_i;
    logic                  reg_file_write_en_i;
    reg_file_data_source   reg_file_data_source_i;
    logic [ADDR_WIDTH-1:0] reg_dest_addr_i;
    logic [WORD-1:0]       alu_result_i;
    logic [WORD-1:0]       reg_2_data_i;
    logic                  stall_o;
    logic                  dmem_req_o;
    logic                  dmem_we_o;
    logic [WORD-1:0]       dmem_addr_o;
    logic [WORD-1:0]       dmem_wdata_o;
    logic                  dmem_gnt_i;
    logic                  dmem_rvalid_i;
    logic [WORD-1:0]       dmem_rdata_i;
    logic                  is_valid_o;
    logic                  reg_file_write_en_o;
    logic [ADDR_WIDTH-1:0] reg_dest_addr_o;
    logic [WORD-1:0]       result_o;
    logic                  err_o;

    int passed = 0;
    int total  = 0;
    int stall_cycles;

    always #5 clk_i = ~clk_i;

    memory_access_unit dut (
        .clk_i                  (clk_i),
        .reset_i                (reset_i),
        .is_valid_i             (is_valid_i),
        .mem_write_en_i         (mem_write_en_i),
        .reg_file_write_en_i    (reg_file_write_en_i),
        .reg_file_data_source_i (reg_file_data_source_i),
        .reg_dest_addr_i        (reg_dest_addr_i),
        .alu_result_i           (alu_result_i),
        .reg_2_data_i           (reg_2_data_i),
        .stall_o                (stall_o),
        .dmem_req_o             (dmem_req_o),
        .dmem_we_o              (dmem_we_o),
        .dmem_addr_o            (dmem_addr_o),
        .dmem_wdata_o           (dmem_wdata_o),
        .dmem_gnt_i             (dmem_gnt_i),
        .dmem_rvalid_i          (dmem_rvalid_i),
        .dmem_rdata_i           (dmem_rdata_i),
        .is_valid_o             (is_valid_o),
        .reg_file_write_en_o    (reg_file_write_en_o),
        .reg_dest_addr_o        (reg_dest_addr_o),
        .result_o               (result_o),
        .err_o                  (err_o)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic mw, input logic we,
                         input reg_file_data_source src, input logic [ADDR_WIDTH-1:0] dest,
                         input logic [WORD-1:0] alu, input logic [WORD-1:0] r2);
        is_valid_i             = v;
        mem_write_en_i         = mw;
        reg_file_write_en_i    = we;
        reg_file_data_source_i = src;
        reg_dest_addr_i        = dest;
        alu_result_i           = alu;
        reg_2_data_i           = r2;
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 1'b0, ALU_RESULT, '0, '0, '0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"},  {31'd0, stall_o},             32'd0);
        check({tag, "_req"},    {31'd0, dmem_req_o},          32'd0);
        check({tag, "_we"},     {31'd0, dmem_we_o},           32'd0);
        check({tag, "_addr"},   dmem_addr_o,                  32'd0);
        check({tag, "_wdata"},  dmem_wdata_o,                 32'd0);
        check({tag, "_valid"},  {31'd0, is_valid_o},          32'd0);
        check({tag, "_rfwe"},   {31'd0, reg_file_write_en_o}, 32'd0);
        check({tag, "_dest"},   {28'd0, reg_dest_addr_o},     32'd0);
        check({tag, "_result"}, result_o,                     32'd0);
        check({tag, "_err"},    {31'd0, err_o},               32'd0);
    endtask

    initial begin
        reset_i       = 1'b1;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = '0;
        bubble();
        step();
        step();
        check_all_zero("reset");
        reset_i = 1'b0;

        // ADD r3 = 0x42
        drive(1'b1, 1'b0, 1'b1, ALU_RESULT, 4'd3, 32'h0000_0042, 32'h0);
        check("add_stall_pre", {31'd0, stall_o}, 32'd0);
        step();
        bubble();
        check("add_valid",  {31'd0, is_valid_o},          32'd1);
        check("add_result", result_o,                     32'h0000_0042);
        check("add_dest",   {28'd0, reg_dest_addr_o},     32'd3);
        check("add_rfwe",   {31'd0, reg_file_write_en_o}, 32'd1);
        check("add_stall",  {31'd0, stall_o},             32'd0);
        step();
        check("add_valid_drop", {31'd0, is_valid_o}, 32'd0);

        // Store 0xDEADBEEF to 0x100, granted on the first request cycle
        drive(1'b1, 1'b1, 1'b0, ALU_RESULT, 4'd0, 32'h0000_0100, 32'hDEAD_BEEF);
        dmem_gnt_i = 1'b1;
        step();
        bubble();
        check("st_req",   {31'd0, dmem_req_o}, 32'd1);
        check("st_we",    {31'd0, dmem_we_o},  32'd1);
        check("st_addr",  dmem_addr_o,         32'h0000_0100);
        check("st_wdata", dmem_wdata_o,        32'hDEAD_BEEF);
        check("st_stall", {31'd0, stall_o},    32'd1);
        check("st_valid_early", {31'd0, is_valid_o}, 32'd0);
        step();
        dmem_gnt_i = 1'b0;
        check("st_req_drop", {31'd0, dmem_req_o},          32'd0);
        check("st_stall_drop", {31'd0, stall_o},           32'd0);
        check("st_valid",    {31'd0, is_valid_o},          32'd1);
        check("st_rfwe",     {31'd0, reg_file_write_en_o}, 32'd0);
        check("st_result",   result_o,                     32'h0000_0100);
        step();
        check("st_valid_once", {31'd0, is_valid_o}, 32'd0);

        // Load r5 from 0x200: grant after 3 waiting cycles, rvalid 2 cycles later
        drive(1'b1, 1'b0, 1'b1, MEM_DATA, 4'd5, 32'h0000_0200, 32'h0);
        stall_cycles = 0;
        step();
        bubble();
        if (stall_o) stall_cycles++;
        check("ld_req", {31'd0, dmem_req_o}, 32'd1);
        check("ld_we",  {31'd0, dmem_we_o},  32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            if (stall_o) stall_cycles++;
            check("ld_addr_stable", dmem_addr_o,         32'h0000_0200);
            check("ld_req_held",    {31'd0, dmem_req_o}, 32'd1);
        end
        dmem_gnt_i = 1'b1;
        step();
        if (stall_o) stall_cycles++;
        dmem_gnt_i = 1'b0;
        check("ld_wait_req", {31'd0, dmem_req_o}, 32'd0);
        step();
        if (stall_o) stall_cycles++;
        check("ld_wait_valid", {31'd0, is_valid_o}, 32'd0);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h1234_5678;
        step();
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = '0;
        check("ld_stall_cycles", stall_cycles,                32'd6);
        check("ld_valid",        {31'd0, is_valid_o},         32'd1);
        check("ld_result",       result_o,                    32'h1234_5678);
        check("ld_dest",         {28'd0, reg_dest_addr_o},    32'd5);
        check("ld_rfwe",         {31'd0, reg_file_write_en_o}, 32'd1);
        check("ld_stall_drop",   {31'd0, stall_o},            32'd0);

        // Misaligned load at 0x202
        drive(1'b1, 1'b0, 1'b1, MEM_DATA, 4'd6, 32'h0000_0202, 32'h0);
        step();
        bubble();
        check("mis_err",   {31'd0, err_o},      32'd1);
        check("mis_req",   {31'd0, dmem_req_o}, 32'd0);
        check("mis_valid", {31'd0, is_valid_o}, 32'd0);
        check("mis_stall", {31'd0, stall_o},    32'd0);
        step();
        check("mis_err_once", {31'd0, err_o}, 32'd0);

        // Store flagged also as load source behaves as a plain store
        drive(1'b1, 1'b1, 1'b0, MEM_DATA, 4'd1, 32'h0000_0104, 32'h0BAD_F00D);
        dmem_gnt_i = 1'b1;
        step();
        bubble();
        check("both_we", {31'd0, dmem_we_o}, 32'd1);
        step();
        dmem_gnt_i = 1'b0;
        check("both_valid",  {31'd0, is_valid_o}, 32'd1);
        check("both_result", result_o,            32'h0000_0104);
        step();

        // Load r7 then ADD r2: ADD is held during the stall
        drive(1'b1, 1'b0, 1'b1, MEM_DATA, 4'd7, 32'h0000_0300, 32'h0);
        step();
        drive(1'b1, 1'b0, 1'b1, ALU_RESULT, 4'd2, 32'h0000_0055, 32'h0);
        dmem_gnt_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0;
        check("b2b_hold", {31'd0, is_valid_o}, 32'd0);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hCAFE_F00D;
        step();
        dmem_rvalid_i = 1'b0;
        check("b2b_ld_result", result_o,                 32'hCAFE_F00D);
        check("b2b_ld_dest",   {28'd0, reg_dest_addr_o}, 32'd7);
        step();
        bubble();
        check("b2b_add_valid",  {31'd0, is_valid_o},      32'd1);
        check("b2b_add_result", result_o,                 32'h0000_0055);
        check("b2b_add_dest",   {28'd0, reg_dest_addr_o}, 32'd2);
        step();
        check("b2b_valid_drop", {31'd0, is_valid_o}, 32'd0);

        // Reset while waiting for read data; late rvalid must be ignored
        drive(1'b1, 1'b0, 1'b1, MEM_DATA, 4'd4, 32'h0000_0400, 32'h0);
        step();
        bubble();
        dmem_gnt_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0;
        check("rst_in_wait", {31'd0, stall_o}, 32'd1);
        reset_i = 1'b1;
        #1;
        check_all_zero("rst_async");
        step();
        reset_i = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hFFFF_FFFF;
        step();
        dmem_rvalid_i = 1'b0;
        check("rst_late_rvalid_valid",  {31'd0, is_valid_o}, 32'd0);
        check("rst_late_rvalid_stall",  {31'd0, stall_o},    32'd0);
        check("rst_late_rvalid_result", result_o,            32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
